// File: rtl/regfile_hilo_if.sv
// Bus between the WB/ID pipeline stages and the architectural register file.
// The master side (pipeline) drives the WB write bus and the read indices;
// the slave side (register file) returns GPR and HI/LO read data.
interface regfile_hilo_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int BUS_W  = 1 + 2*DATA_W + 1 + ADDR_W + DATA_W
);
  logic [BUS_W-1:0]  wb_to_rf_bus;
  logic [ADDR_W-1:0] raddr1;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;
  logic [DATA_W-1:0] hi_rdata;
  logic [DATA_W-1:0] lo_rdata;

  modport master (
    output wb_to_rf_bus, raddr1, raddr2,
    input  rdata1, rdata2, hi_rdata, lo_rdata
  );

  modport slave (
    input  wb_to_rf_bus, raddr1, raddr2,
    output rdata1, rdata2, hi_rdata, lo_rdata
  );
endinterface

// File: rtl/regfile_hilo.sv
// Architectural register file: 32 GPRs ($0 reads as zero) plus HI/LO.
// Writes arrive on the packed WB bus and commit on posedge clk. Reads are
// combinational, and a write in flight this cycle is forwarded to the read
// ports so the decode stage never needs its own WB forwarding path.
module regfile_hilo #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int BUS_W  = 1 + 2*DATA_W + 1 + ADDR_W + DATA_W
) (
  input  logic           clk,
  input  logic           resetn,
  regfile_hilo_if.slave  rf
);
  localparam int NREG = 1 << ADDR_W;

  logic                hilo_we;
  logic [2*DATA_W-1:0] hilo_wdata;
  logic                rf_we;
  logic [ADDR_W-1:0]   rf_waddr;
  logic [DATA_W-1:0]   rf_wdata;
  logic [DATA_W-1:0]   hilo_hi;
  logic [DATA_W-1:0]   hilo_lo;
  logic                gpr_we;

  // Entry 0 is reset to zero and never written; reads of $0 never touch it.
  logic [DATA_W-1:0]   gpr [0:NREG-1];
  logic [DATA_W-1:0]   hi_q;
  logic [DATA_W-1:0]   lo_q;

  assign {hilo_we, hilo_wdata, rf_we, rf_waddr, rf_wdata} = rf.wb_to_rf_bus;
  assign hilo_hi = hilo_wdata[2*DATA_W-1:DATA_W];
  assign hilo_lo = hilo_wdata[DATA_W-1:0];
  // Writes to $0 are dropped here, which also removes them from the bypass.
  assign gpr_we  = rf_we && (rf_waddr != '0);

  // Commit WB writes; reset clears every register without needing a clock.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NREG; i++) begin
        gpr[i] <= '0;
      end
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (gpr_we) begin
        gpr[rf_waddr] <= rf_wdata;
      end
      if (hilo_we) begin
        hi_q <= hilo_hi;
        lo_q <= hilo_lo;
      end
    end
  end

  // Read ports with same-cycle bypass; everything reads zero while in reset.
  always_comb begin
    rf.rdata1   = '0;
    rf.rdata2   = '0;
    rf.hi_rdata = '0;
    rf.lo_rdata = '0;
    if (resetn) begin
      if (rf.raddr1 == '0) begin
        rf.rdata1 = '0;
      end else if (gpr_we && (rf_waddr == rf.raddr1)) begin
        rf.rdata1 = rf_wdata;
      end else begin
        rf.rdata1 = gpr[rf.raddr1];
      end

      if (rf.raddr2 == '0) begin
        rf.rdata2 = '0;
      end else if (gpr_we && (rf_waddr == rf.raddr2)) begin
        rf.rdata2 = rf_wdata;
      end else begin
        rf.rdata2 = gpr[rf.raddr2];
      end

      rf.hi_rdata = hilo_we ? hilo_hi : hi_q;
      rf.lo_rdata = hilo_we ? hilo_lo : lo_q;
    end
  end
endmodule

// File: tb/tb_regfile_hilo.sv
// Directed bench for regfile_hilo: each step drives the WB bus and read
// indices on the falling edge, queues the values the read ports should show,
// and drains the queue either before the next rising edge (bypass view) or
// just after it (committed view).
module tb_regfile_hilo;
  localparam int P_RD1 = 1;
  localparam int P_RD2 = 2;
  localparam int P_HI  = 3;
  localparam int P_LO  = 4;

  typedef struct {
    string       tag;
    int          port;
    logic [31:0] exp;
  } sb_t;

  logic clk;
  logic resetn;
  int   tests;
  int   fails;
  sb_t  sb_q[$];

  regfile_hilo_if bus_if ();

  regfile_hilo dut (
    .clk    (clk),
    .resetn (resetn),
    .rf     (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [102:0] mk_bus(input logic hwe, input logic [63:0] hd,
                                          input logic rwe, input logic [4:0] wa,
                                          input logic [31:0] wd);
    return {hwe, hd, rwe, wa, wd};
  endfunction

  task automatic drive(input logic hwe, input logic [63:0] hd, input logic rwe,
                       input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] ra1, input logic [4:0] ra2);
    bus_if.wb_to_rf_bus = mk_bus(hwe, hd, rwe, wa, wd);
    bus_if.raddr1       = ra1;
    bus_if.raddr2       = ra2;
  endtask

  task automatic sb_push(input string tag, input int port, input logic [31:0] exp);
    sb_t e;
    e.tag  = tag;
    e.port = port;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  task automatic sb_drain();
    sb_t         e;
    logic [31:0] obs;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      case (e.port)
        P_RD1:   obs = bus_if.rdata1;
        P_RD2:   obs = bus_if.rdata2;
        P_HI:    obs = bus_if.hi_rdata;
        default: obs = bus_if.lo_rdata;
      endcase
      tests++;
      assert (obs === e.exp) else begin
        fails++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests  = 0;
    fails  = 0;
    resetn = 1'b0;
    // Write attempts while in reset must be neither visible nor committed.
    drive(1'b1, 64'h9_0000_0009, 1'b1, 5'd3, 32'h0000_0077, 5'd3, 5'd5);
    #1;
    sb_push("rst_rd1_gated", P_RD1, 32'h0);
    sb_push("rst_rd2_zero",  P_RD2, 32'h0);
    sb_push("rst_hi_gated",  P_HI,  32'h0);
    sb_push("rst_lo_gated",  P_LO,  32'h0);
    sb_drain();
    after_edge();
    after_edge();

    @(negedge clk);
    drive(1'b0, 64'h0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd0);
    resetn = 1'b1;
    #1;
    sb_push("rst_write_ignored", P_RD1, 32'h0);
    sb_push("rst_hilo_ignored",  P_HI,  32'h0);
    sb_drain();

    // Plain write then read on both ports.
    @(negedge clk);
    drive(1'b0, 64'h0, 1'b1, 5'd7, 32'h1234_5678, 5'd0, 5'd0);
    after_edge();
    @(negedge clk);
    drive(1'b0, 64'h0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd7);
    #1;
    sb_push("wr7_rd1", P_RD1, 32'h1234_5678);
    sb_push("wr7_rd2", P_RD2, 32'h1234_5678);
    sb_drain();

    // Same-cycle bypass; port 2 looks at a different register.
    @(negedge clk);
    drive(1'b0, 64'h0, 1'b1, 5'd9, 32'hA5A5_A5A5, 5'd9, 5'd7);
    #1;
    sb_push("byp9_rd1",     P_RD1, 32'hA5A5_A5A5);
    sb_push("byp9_rd2_oth", P_RD2, 32'h1234_5678);
    sb_drain();
    @(negedge clk);
    drive(1'b0, 64'h0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd9);
    #1;
    sb_push("r9_held_rd1", P_RD1, 32'hA5A5_A5A5);
    sb_push("r9_held_rd2", P_RD2, 32'hA5A5_A5A5);
    sb_drain();

    // Bypass must win over the stale stored value.
    @(negedge clk);
    drive(1'b0, 64'h0, 1'b1, 5'd7, 32'h0BAD_F00D, 5'd7, 5'd9);
    #1;
    sb_push("byp7_over_old", P_RD1, 32'h0BAD_F00D);
    sb_push("byp7_rd2_r9",   P_RD2, 32'hA5A5_A5A5);
    sb_drain();
    after_edge();
    sb_push("r7_new_commit", P_RD1, 32'h0BAD_F00D);
    sb_drain();

    // Writes to $0 are dropped and never bypassed.
    @(negedge clk);
    drive(1'b0, 64'h0, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
    #1;
    sb_push("r0_nobyp_rd1", P_RD1, 32'h0);
    sb_push("r0_nobyp_rd2", P_RD2, 32'h0);
    sb_drain();
    after_edge();
    sb_push("r0_after_edge", P_RD1, 32'h0);
    sb_drain();

    // HI/LO bypass, commit and hold.
    @(negedge clk);
    drive(1'b1, 64'h0000_0003_0000_0007, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    #1;
    sb_push("hilo_byp_hi", P_HI, 32'h3);
    sb_push("hilo_byp_lo", P_LO, 32'h7);
    sb_drain();
    after_edge();
    sb_push("hilo_edge_hi", P_HI, 32'h3);
    sb_push("hilo_edge_lo", P_LO, 32'h7);
    sb_drain();
    @(negedge clk);
    drive(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    #1;
    sb_push("hilo_hold_hi", P_HI, 32'h3);
    sb_push("hilo_hold_lo", P_LO, 32'h7);
    sb_drain();

    // Concurrent GPR and HI/LO writes; a neighbouring register stays put.
    @(negedge clk);
    drive(1'b0, 64'h0, 1'b1, 5'd30, 32'h0000_CAFE, 5'd0, 5'd0);
    after_edge();
    @(negedge clk);
    drive(1'b1, 64'h0000_0001_0000_0002, 1'b1, 5'd31, 32'h0000_0055, 5'd31, 5'd30);
    after_edge();
    @(negedge clk);
    drive(1'b0, 64'h0, 1'b0, 5'd0, 32'h0, 5'd31, 5'd30);
    #1;
    sb_push("conc_hi",    P_HI,  32'h1);
    sb_push("conc_lo",    P_LO,  32'h2);
    sb_push("conc_r31",   P_RD1, 32'h0000_0055);
    sb_push("conc_r30",   P_RD2, 32'h0000_CAFE);
    sb_drain();

    // Reset asserted between edges clears state immediately.
    @(negedge clk);
    drive(1'b1, 64'h0000_0001_0000_0000, 1'b1, 5'd5, 32'hDEAD_BEEF, 5'd0, 5'd0);
    after_edge();
    @(negedge clk);
    drive(1'b0, 64'h0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd7);
    #1;
    sb_push("pre_rst_r5", P_RD1, 32'hDEAD_BEEF);
    sb_push("pre_rst_hi", P_HI,  32'h1);
    sb_drain();
    #1;
    resetn = 1'b0;
    #1;
    sb_push("in_rst_r5", P_RD1, 32'h0);
    sb_push("in_rst_hi", P_HI,  32'h0);
    sb_drain();
    resetn = 1'b1;
    #1;
    sb_push("post_rst_r5", P_RD1, 32'h0);
    sb_push("post_rst_r7", P_RD2, 32'h0);
    sb_push("post_rst_hi", P_HI,  32'h0);
    sb_push("post_rst_lo", P_LO,  32'h0);
    sb_drain();

    // First write after reset release commits normally.
    @(negedge clk);
    drive(1'b0, 64'h0, 1'b1, 5'd5, 32'h0000_0001, 5'd0, 5'd0);
    after_edge();
    @(negedge clk);
    drive(1'b0, 64'h0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd0);
    #1;
    sb_push("wr_after_rst", P_RD1, 32'h0000_0001);
    sb_drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
